lsu: RTL and testbench

Load/store unit for the RV32I datapath. Sits directly upstream of the byte-writable data memory (`v_rams_02b`) and drives its `daddr`/`indata`/`we` ports while consuming its `outdata`. Accepts one load or store request at a time over a valid/ready handshake. Performs RV32I byte-lane alignment, write-enable generation, load extraction with sign/zero extension, and misalignment detection.

---
 rtl/lsu_pkg.sv | 25 ++
 rtl/lsu_align.sv | 56 +++++
 rtl/lsu.sv | 132 +++++++++++++
 tb/tb_lsu.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared constants and types for the RV32I load/store unit
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        WAIT,
        CAPTURE,
        RESP
    } lsu_state_t;

    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 4;

    function automatic logic mem_lat_ok(input int lat);
        return (lat >= MEM_LAT_MIN) && (lat <= MEM_LAT_MAX);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane alignment, write enables, load extension and fault decode
module lsu_align
    import lsu_pkg::*;
(
    input  logic        store,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] outdata,
    output logic        fault,
    output logic [31:0] st_data,
    output logic [3:0]  st_we,
    output logic [31:0] ld_data
);

    logic [31:0] shifted;

    always_comb begin
        // Stores only exist for B/H/W, so any store funct3 from 011 upward is illegal.
        fault = store && (funct3 >= 3'b011);
        case (funct3)
            F3_B, F3_BU: ;
            F3_H, F3_HU: if (addr_lo[0]) fault = 1'b1;
            F3_W:        if (addr_lo != 2'b00) fault = 1'b1;
            default:     fault = 1'b1;
        endcase
    end

    always_comb begin
        st_data = wdata;
        st_we   = 4'b1111;
        case (funct3[1:0])
            2'b00: begin
                st_data = {4{wdata[7:0]}};
                st_we   = 4'b0001 << addr_lo;
            end
            2'b01: begin
                st_data = {2{wdata[15:0]}};
                st_we   = 4'b0011 << {addr_lo[1], 1'b0};
            end
            default: ;
        endcase
    end

    always_comb begin
        shifted = outdata >> {addr_lo, 3'b000};
        case (funct3)
            F3_B:    ld_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   ld_data = {24'h0, shifted[7:0]};
            F3_H:    ld_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   ld_data = {16'h0, shifted[15:0]};
            default: ld_data = shifted;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - RV32I load/store unit driving a byte-writable synchronous data memory
module lsu
    import lsu_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_misalign,
    output logic [31:0] daddr,
    output logic [31:0] indata,
    output logic [3:0]  we,
    input  logic [31:0] outdata
);

    if (!mem_lat_ok(MEM_LAT)) begin : g_mem_lat_illegal
        $error("lsu: MEM_LAT must be within 1..4");
    end

    lsu_state_t  state;
    logic        r_store;
    logic [2:0]  r_funct3;
    logic [1:0]  r_addr_lo;
    logic [1:0]  wait_cnt;

    logic        idle;
    logic        a_store;
    logic [2:0]  a_funct3;
    logic [1:0]  a_addr_lo;
    logic        a_fault;
    logic [31:0] st_data;
    logic [3:0]  st_we;
    logic [31:0] ld_data;

    assign idle      = (state == IDLE);
    assign req_ready = idle;

    // The aligner sees the live request while idle (decode on accept) and the
    // registered request afterwards (load extraction in CAPTURE).
    assign a_store   = idle ? req_store      : r_store;
    assign a_funct3  = idle ? req_funct3     : r_funct3;
    assign a_addr_lo = idle ? req_addr[1:0]  : r_addr_lo;

    lsu_align u_align (
        .store   (a_store),
        .funct3  (a_funct3),
        .addr_lo (a_addr_lo),
        .wdata   (req_wdata),
        .outdata (outdata),
        .fault   (a_fault),
        .st_data (st_data),
        .st_we   (st_we),
        .ld_data (ld_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            r_store       <= 1'b0;
            r_funct3      <= 3'b000;
            r_addr_lo     <= 2'b00;
            wait_cnt      <= 2'b00;
            daddr         <= 32'h0;
            indata        <= 32'h0;
            we            <= 4'b0000;
            resp_valid    <= 1'b0;
            resp_rdata    <= 32'h0;
            resp_misalign <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        r_store   <= req_store;
                        r_funct3  <= req_funct3;
                        r_addr_lo <= req_addr[1:0];
                        if (a_fault) begin
                            state         <= RESP;
                            resp_valid    <= 1'b1;
                            resp_misalign <= 1'b1;
                            resp_rdata    <= 32'h0;
                        end else begin
                            state <= ACCESS;
                            daddr <= {req_addr[31:2], 2'b00};
                            if (req_store) begin
                                indata <= st_data;
                                we     <= st_we;
                            end
                        end
                    end
                end
                ACCESS: begin
                    we <= 4'b0000;
                    if (r_store) begin
                        state         <= RESP;
                        resp_valid    <= 1'b1;
                        resp_misalign <= 1'b0;
                        resp_rdata    <= 32'h0;
                    end else if (MEM_LAT == 1) begin
                        state <= CAPTURE;
                    end else begin
                        state    <= WAIT;
                        wait_cnt <= 2'(MEM_LAT - 2);
                    end
                end
                WAIT: begin
                    if (wait_cnt == 2'd0) state <= CAPTURE;
                    else                  wait_cnt <= wait_cnt - 2'd1;
                end
                CAPTURE: begin
                    state         <= RESP;
                    resp_valid    <= 1'b1;
                    resp_misalign <= 1'b0;
                    resp_rdata    <= ld_data;
                end
                RESP: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - scoreboard bench for lsu with MEM_LAT 1 and 3 instances
module tb_lsu;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   we_cycles_a = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic        req_valid_a, req_store_a, req_ready_a, resp_valid_a, resp_misalign_a;
    logic [2:0]  req_funct3_a;
    logic [31:0] req_addr_a, req_wdata_a, resp_rdata_a, daddr_a, indata_a, outdata_a;
    logic [3:0]  we_a;

    logic        req_valid_b, req_store_b, req_ready_b, resp_valid_b, resp_misalign_b;
    logic [2:0]  req_funct3_b;
    logic [31:0] req_addr_b, req_wdata_b, resp_rdata_b, daddr_b, indata_b, outdata_b;
    logic [3:0]  we_b;

    lsu #(.MEM_LAT(1)) dut_a (
        .clk(clk), .reset(reset),
        .req_valid(req_valid_a), .req_ready(req_ready_a), .req_store(req_store_a),
        .req_funct3(req_funct3_a), .req_addr(req_addr_a), .req_wdata(req_wdata_a),
        .resp_valid(resp_valid_a), .resp_rdata(resp_rdata_a), .resp_misalign(resp_misalign_a),
        .daddr(daddr_a), .indata(indata_a), .we(we_a), .outdata(outdata_a)
    );

    lsu #(.MEM_LAT(3)) dut_b (
        .clk(clk), .reset(reset),
        .req_valid(req_valid_b), .req_ready(req_ready_b), .req_store(req_store_b),
        .req_funct3(req_funct3_b), .req_addr(req_addr_b), .req_wdata(req_wdata_b),
        .resp_valid(resp_valid_b), .resp_rdata(resp_rdata_b), .resp_misalign(resp_misalign_b),
        .daddr(daddr_b), .indata(indata_b), .we(we_b), .outdata(outdata_b)
    );

    // Byte-writable memories: one-cycle read for A, three-stage read pipe for B.
    logic [31:0] mem_a [0:255];
    logic [31:0] mem_b [0:255];
    logic [31:0] pipe_b1, pipe_b2;

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we_a[i]) mem_a[daddr_a[9:2]][8*i +: 8] <= indata_a[8*i +: 8];
            if (we_b[i]) mem_b[daddr_b[9:2]][8*i +: 8] <= indata_b[8*i +: 8];
        end
        outdata_a <= mem_a[daddr_a[9:2]];
        pipe_b1   <= mem_b[daddr_b[9:2]];
        pipe_b2   <= pipe_b1;
        outdata_b <= pipe_b2;
    end

    typedef struct {
        int          cyc;
        logic        mis;
        logic [31:0] rdata;
        string       name;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin : mon_a
        exp_t e;
        if (we_a != 4'b0000) we_cycles_a <= we_cycles_a + 1;
        if (resp_valid_a) begin
            if (q_a.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL resp_a_unexpected: got resp_valid=1 rdata=%h, expected no response", resp_rdata_a);
            end else begin
                e = q_a.pop_front();
                chk({e.name, "_misalign"}, 32'(resp_misalign_a), 32'(e.mis));
                chk({e.name, "_rdata"}, resp_rdata_a, e.rdata);
                chk({e.name, "_cycle"}, cyc, e.cyc);
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (resp_valid_b) begin
            if (q_b.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL resp_b_unexpected: got resp_valid=1 rdata=%h, expected no response", resp_rdata_b);
            end else begin
                e = q_b.pop_front();
                chk({e.name, "_misalign"}, 32'(resp_misalign_b), 32'(e.mis));
                chk({e.name, "_rdata"}, resp_rdata_b, e.rdata);
                chk({e.name, "_cycle"}, cyc, e.cyc);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic issue_a(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input int lat, input logic mis,
                           input logic [31:0] rdata, input bit push, input string nm,
                           output int c0);
        int guard = 0;
        while (!req_ready_a && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk({nm, "_ready_before_accept"}, 32'(req_ready_a), 32'h1);
        req_valid_a  = 1'b1;
        req_store_a  = st;
        req_funct3_a = f3;
        req_addr_a   = addr;
        req_wdata_a  = wdata;
        @(posedge clk);
        #1;
        c0 = cyc;
        if (push) q_a.push_back('{cyc: c0 + lat, mis: mis, rdata: rdata, name: nm});
        @(negedge clk);
        req_valid_a = 1'b0;
        req_addr_a  = 32'hDEAD_BEEF;
        req_wdata_a = 32'h0;
    endtask

    task automatic store_a(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] exp_we, input logic [31:0] exp_in, input string nm,
                           output int c0);
        issue_a(1'b1, f3, addr, wdata, 1, 1'b0, 32'h0, 1'b1, nm, c0);
        chk({nm, "_daddr"}, daddr_a, {addr[31:2], 2'b00});
        chk({nm, "_we"}, 32'(we_a), 32'(exp_we));
        chk({nm, "_indata"}, indata_a, exp_in);
        @(negedge clk);
        chk({nm, "_we_after"}, 32'(we_a), 32'h0);
    endtask

    task automatic load_a(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] exp,
                          input string nm);
        int c0;
        issue_a(1'b0, f3, addr, 32'h0, 2, 1'b0, exp, 1'b1, nm, c0);
    endtask

    task automatic fault_a(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                           input string nm);
        int c0;
        issue_a(st, f3, addr, 32'hFFFF_FFFF, 0, 1'b1, 32'h0, 1'b1, nm, c0);
    endtask

    task automatic issue_b(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input int lat, input logic [31:0] rdata,
                           input int hold, input string nm);
        int guard = 0;
        int c0;
        while (!req_ready_b && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk({nm, "_ready_before_accept"}, 32'(req_ready_b), 32'h1);
        req_valid_b  = 1'b1;
        req_store_b  = st;
        req_funct3_b = f3;
        req_addr_b   = addr;
        req_wdata_b  = wdata;
        @(posedge clk);
        #1;
        c0 = cyc;
        q_b.push_back('{cyc: c0 + lat, mis: 1'b0, rdata: rdata, name: nm});
        @(negedge clk);
        req_addr_b = addr + 32'h4;
        for (int i = 0; i < hold; i++) begin
            chk({nm, "_busy_ready"}, 32'(req_ready_b), 32'h0);
            @(negedge clk);
        end
        req_valid_b = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int c0, c1, guard;
        reset = 1'b1;
        req_valid_a = 1'b0; req_store_a = 1'b0; req_funct3_a = 3'b000; req_addr_a = 32'h0; req_wdata_a = 32'h0;
        req_valid_b = 1'b0; req_store_b = 1'b0; req_funct3_b = 3'b000; req_addr_b = 32'h0; req_wdata_b = 32'h0;
        repeat (3) @(negedge clk);
        req_valid_a = 1'b1;
        @(negedge clk);
        req_valid_a = 1'b0;
        reset = 1'b0;

        chk("reset_req_ready", 32'(req_ready_a), 32'h1);
        chk("reset_we", 32'(we_a), 32'h0);
        chk("reset_daddr", daddr_a, 32'h0);
        chk("reset_indata", indata_a, 32'h0);
        chk("reset_resp_valid", 32'(resp_valid_a), 32'h0);
        chk("reset_resp_rdata", resp_rdata_a, 32'h0);
        chk("reset_resp_misalign", 32'(resp_misalign_a), 32'h0);
        chk("reset_req_ready_b", 32'(req_ready_b), 32'h1);

        store_a(3'b010, 32'h100, 32'h80FF_1234, 4'b1111, 32'h80FF_1234, "sw_100", c0);
        load_a(3'b000, 32'h102, 32'hFFFF_FFFF, "lb_102");
        load_a(3'b100, 32'h102, 32'h0000_00FF, "lbu_102");
        load_a(3'b001, 32'h102, 32'hFFFF_80FF, "lh_102");
        load_a(3'b101, 32'h102, 32'h0000_80FF, "lhu_102");
        load_a(3'b000, 32'h100, 32'h0000_0034, "lb_100");
        load_a(3'b000, 32'h103, 32'hFFFF_FF80, "lb_103");
        load_a(3'b010, 32'h100, 32'h80FF_1234, "lw_100");

        store_a(3'b000, 32'h103, 32'hAABB_CC7F, 4'b1000, 32'h7F7F_7F7F, "sb_103", c0);
        load_a(3'b010, 32'h100, 32'h7FFF_1234, "lw_after_sb");
        store_a(3'b001, 32'h102, 32'h1234_BEEF, 4'b1100, 32'hBEEF_BEEF, "sh_102", c0);
        load_a(3'b010, 32'h100, 32'hBEEF_1234, "lw_after_sh");
        load_a(3'b001, 32'h100, 32'h0000_1234, "lh_100");

        fault_a(1'b0, 3'b010, 32'h101, "lw_101_fault");
        fault_a(1'b0, 3'b001, 32'h101, "lh_101_fault");
        fault_a(1'b0, 3'b101, 32'h103, "lhu_103_fault");
        fault_a(1'b0, 3'b011, 32'h100, "f3_011_fault");
        fault_a(1'b0, 3'b110, 32'h100, "f3_110_fault");
        fault_a(1'b0, 3'b111, 32'h100, "f3_111_fault");
        fault_a(1'b1, 3'b100, 32'h100, "sbu_fault");
        fault_a(1'b1, 3'b011, 32'h100, "store_f3_011_fault");
        load_a(3'b010, 32'h100, 32'hBEEF_1234, "lw_after_faults");

        // Reset during the ACCESS cycle of a store: no response may follow.
        issue_a(1'b1, 3'b010, 32'h080, 32'h5555_AAAA, 1, 1'b0, 32'h0, 1'b0, "sw_reset", c0);
        chk("sw_reset_we_access", 32'(we_a), 32'hF);
        reset = 1'b1;
        @(negedge clk);
        chk("sw_reset_we_after", 32'(we_a), 32'h0);
        chk("sw_reset_resp_valid", 32'(resp_valid_a), 32'h0);
        chk("sw_reset_req_ready", 32'(req_ready_a), 32'h1);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        store_a(3'b010, 32'h300, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D, "b2b_sw", c0);
        issue_a(1'b0, 3'b010, 32'h300, 32'h0, 2, 1'b0, 32'hCAFE_F00D, 1'b1, "b2b_lw", c1);
        chk("b2b_accept_cycle", c1, c0 + 3);

        issue_b(1'b1, 3'b010, 32'h200, 32'h1234_5678, 1, 32'h0, 0, "b_sw_200");
        issue_b(1'b0, 3'b010, 32'h200, 32'h0, 4, 32'h1234_5678, 4, "b_lw_200");
        @(negedge clk);
        chk("b_ready_after_lw", 32'(req_ready_b), 32'h1);

        guard = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        repeat (4) @(negedge clk);
        chk("q_a_drained", q_a.size(), 32'h0);
        chk("q_b_drained", q_b.size(), 32'h0);
        chk("we_active_cycles_a", we_cycles_a, 32'd5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
